// File: rtl/motoro301_pkg.sv
// Shared definitions for the UART command receiver: command bytes,
// receive FSM encoding and the default bit period.
package motoro301_pkg;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Receive FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ASCII command bytes (case-sensitive)
    localparam logic [7:0] CMD_START = 8'h53; // 'S'
    localparam logic [7:0] CMD_STOP  = 8'h54; // 'T'
    localparam logic [7:0] CMD_FSTOP = 8'h58; // 'X'
    localparam logic [7:0] CMD_INV   = 8'h52; // 'R'
    localparam logic [7:0] CMD_INC   = 8'h2B; // '+'
    localparam logic [7:0] CMD_DEC   = 8'h2D; // '-'

    // True when the byte is one of the recognised commands
    function automatic logic is_command(input logic [7:0] b);
        logic hit;
        case (b)
            CMD_START, CMD_STOP, CMD_FSTOP,
            CMD_INV, CMD_INC, CMD_DEC: hit = 1'b1;
            default:                   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/motoro301_uart_rx.sv
// UART 8N1 receiver: input synchroniser, start/data/stop FSM and the
// raw byte / valid / framing-error strobes (one cycle each).
module motoro301_uart_rx
    import motoro301_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [1:0]  state_q,     state_d;
    logic [15:0] baud_q,      baud_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  byte_q,      byte_d;
    logic        valid_q,     valid_d;
    logic        frame_err_q, frame_err_d;

    // Synchroniser flops reset to idle-high so release never looks like a start bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Next-state logic: half-bit start qualification, then full-bit sampling
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d    = 16'd0;
                bit_cnt_d = 3'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = 16'd0;
                    // Line back high at mid-start: treat as a glitch
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d    = 16'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = 16'd0;
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                baud_d    = 16'd0;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            baud_q      <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign byte_o      = byte_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/motoro301_uart_cmd_rx.sv
// UART command receiver top: turns received ASCII bytes into the motor
// controller's level requests and frequency step pulses.
module motoro301_uart_cmd_rx
    import motoro301_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk50mhz,
    input  logic       reset,
    input  logic       uRx,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       frameErr,
    output logic       cmdErr,
    output logic       m3start,
    output logic       m3forceStop,
    output logic       m3invRotate,
    output logic       m3freqINC,
    output logic       m3freqDEC
);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       frame_err_s;

    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_valid_q,  rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       cmd_err_q,   cmd_err_d;
    logic       start_q,     start_d;
    logic       fstop_q,     fstop_d;
    logic       inv_q,       inv_d;
    logic       inc_q,       inc_d;
    logic       dec_q,       dec_d;

    motoro301_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk_i       (clk50mhz),
        .rst_i       (reset),
        .rx_i        (uRx),
        .byte_o      (rx_byte_s),
        .valid_o     (rx_valid_s),
        .frame_err_o (frame_err_s)
    );

    // Command decode; the raw strobes are re-timed so every output moves on the same edge
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_s;
        frame_err_d = frame_err_s;
        cmd_err_d   = 1'b0;
        start_d     = start_q;
        fstop_d     = fstop_q;
        inv_d       = inv_q;
        inc_d       = 1'b0;
        dec_d       = 1'b0;
        if (rx_valid_s) begin
            rx_data_d = rx_byte_s;
            case (rx_byte_s)
                CMD_START: begin
                    start_d = 1'b1;
                    fstop_d = 1'b0;
                end
                CMD_STOP:  start_d = 1'b0;
                CMD_FSTOP: begin
                    fstop_d = 1'b1;
                    start_d = 1'b0;
                end
                CMD_INV:   inv_d   = ~inv_q;
                CMD_INC:   inc_d   = 1'b1;
                CMD_DEC:   dec_d   = 1'b1;
                default:   cmd_err_d = ~is_command(rx_byte_s);
            endcase
        end else begin
            cmd_err_d = 1'b0;
        end
    end

    // Output registers; reset clears every output at once, including mid-frame
    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            start_q     <= 1'b0;
            fstop_q     <= 1'b0;
            inv_q       <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            cmd_err_q   <= cmd_err_d;
            start_q     <= start_d;
            fstop_q     <= fstop_d;
            inv_q       <= inv_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
        end
    end

    assign rxData      = rx_data_q;
    assign rxValid     = rx_valid_q;
    assign frameErr    = frame_err_q;
    assign cmdErr      = cmd_err_q;
    assign m3start     = start_q;
    assign m3forceStop = fstop_q;
    assign m3invRotate = inv_q;
    assign m3freqINC   = inc_q;
    assign m3freqDEC   = dec_q;

endmodule
